// File: rtl/argon_pkg.sv
// Shared register-file constants and the writeback request payload type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package argon_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] sel;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, starting after the last winner.
// Latency: grant is combinational; the pointer moves on the edge that ends a granted cycle.
// Backpressure: no grant during reset; the caller masks i_req to stall arbitration.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;
    int            cand;

    // Scan from lowest to highest priority so the candidate nearest last_grant+1 wins.
    always_comb begin
        o_grant   = '0;
        grant_idx = last_grant;
        cand      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = (int'(last_grant) + 1 + i) % N;
            if (i_req[cand]) begin
                o_grant       = '0;
                o_grant[cand] = 1'b1;
                grant_idx     = cand[IW-1:0];
            end
        end
        if (i_reset) begin
            o_grant = '0;
        end
    end

    // Pointer follows the winner; reset parks it on N-1 so requester 0 leads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant <= IW'(N - 1);
        end else if (i_advance && (|o_grant)) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources, round-robin.
// Latency: transfer in cycle N drives the write port in cycle N+1; one write per cycle sustained.
// Backpressure: ready withheld during hold/reset; the output stage never stalls.
module regfile_wb_arbiter
    import argon_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_hold,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_sel,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_write_en,
    output logic [ADDR_W-1:0]         o_selectW,
    output logic [DATA_W-1:0]         o_portW,
    output logic [2**ADDR_W-1:0]      o_pending
);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } wb_stage_t;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_mux;
    logic [DATA_W-1:0]  data_mux;
    wb_stage_t          stage_q;

    // Hold masks the requests so the arbiter neither grants nor advances.
    assign arb_req     = i_req_valid & {NUM_REQ{~i_hold}};
    assign o_req_ready = grant;
    assign xfer        = |(grant & i_req_valid);

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (arb_req),
        .i_advance (xfer),
        .o_grant   (grant)
    );

    // Payload mux driven by the one-hot grant; zero when nothing is granted.
    always_comb begin
        sel_mux  = '0;
        data_mux = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_mux  = i_req_sel[k*ADDR_W +: ADDR_W];
                data_mux = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage reloads every cycle; writes to x0 are consumed but never enabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stage_q <= '0;
        end else if (xfer) begin
            stage_q.en   <= (sel_mux != '0);
            stage_q.sel  <= sel_mux;
            stage_q.data <= data_mux;
        end else begin
            stage_q <= '0;
        end
    end

    assign o_write_en = stage_q.en;
    assign o_selectW  = stage_q.sel;
    assign o_portW    = stage_q.data;

    // Pending mask is a one-hot decode of the write currently held in the stage.
    always_comb begin
        o_pending = '0;
        if (stage_q.en) begin
            o_pending[stage_q.sel] = 1'b1;
        end
    end

endmodule
